// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory load/store controller.
//   state_t          : controller FSM states (IDLE, WAIT, RESP)
//   WORD_ALIGN_MASK  : byte-offset bits that must be zero for a word access
//   DEFAULT_TIMEOUT  : default bus wait budget in cycles
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
    localparam int         DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/wait_counter.sv
// Bus wait-cycle counter.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   clear  : synchronous clear (takes priority over enable)
//   enable : count up by one this cycle
//   tc     : terminal count, high while the count equals TIMEOUT-1
module wait_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int          CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store unit between the core's memory stage and a word-wide
// request/acknowledge data bus.
//   clk_i, rst_i        : clock (rising edge), async active-low reset
//   mem_read_i/write_i  : core load / store request (write wins if both)
//   addr_i, wdata_i     : core byte address and store data
//   rdata_o             : load data to the core (held between loads)
//   stall_o             : core must hold PC and suppress register write
//   misaligned_o        : access ignored because addr_i[1:0] != 0
//   err_o               : sticky bus-timeout flag, cleared only by reset
//   bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o : registered bus request
//   bus_ack_i, bus_rdata_i                       : bus completion and read data
//
// Bus handshake: bus_req_o is the valid and bus_ack_i the ready. A transfer
// completes on the rising edge where both are high; bus_we_o, bus_addr_o and
// bus_wdata_o are held stable from the rise of bus_req_o until that edge, and
// bus_rdata_i is sampled only on that edge. bus_ack_i while bus_req_o is low
// has no effect. bus_req_o drops the cycle after the completing edge.
module data_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              misaligned_o,
    output logic              err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i
);

    // FSM state, kept as a named signal so it can be observed directly.
    state_t            state;
    logic [DATA_W-1:0] rdata_q;
    logic              access;
    logic              aligned;
    logic              start;
    logic              tc;
    logic              cnt_en;

    assign access  = mem_read_i | mem_write_i;
    assign aligned = ((addr_i[1:0] & WORD_ALIGN_MASK) == 2'b00);
    assign start   = (state == IDLE) & access & aligned;

    // The core holds its request inputs during reset; gating with rst_i keeps
    // stall and misaligned low while reset is asserted.
    assign misaligned_o = rst_i & (state == IDLE) & access & ~aligned;
    assign stall_o      = rst_i & (start | (state == WAIT));
    assign rdata_o      = misaligned_o ? '0 : rdata_q;

    // Count only while waiting without an ack; stop at terminal count so the
    // counter never wraps.
    assign cnt_en = (state == WAIT) & ~bus_ack_i & ~tc;

    wait_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_counter (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .clear  (start),
        .enable (cnt_en),
        .tc     (tc)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            rdata_q     <= '0;
            err_o       <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                        bus_wdata_o <= wdata_i;
                        bus_we_o    <= mem_write_i;
                        bus_req_o   <= 1'b1;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    // An ack on the terminal-count cycle still completes the access.
                    if (bus_ack_i) begin
                        if (!bus_we_o) begin
                            rdata_q <= bus_rdata_i;
                        end
                        bus_req_o <= 1'b0;
                        state     <= RESP;
                    end else if (tc) begin
                        err_o     <= 1'b1;
                        rdata_q   <= '0;
                        bus_req_o <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    bus_req_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl (TIMEOUT = 4).
module tb_data_mem_ctrl;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        mem_read_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        misaligned_o;
    logic        err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i = 1'b0;
    logic [31:0] bus_rdata_i = 32'hBAD0_BAD0;

    data_mem_ctrl #(.TIMEOUT(TO), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .stall_o      (stall_o),
        .misaligned_o (misaligned_o),
        .err_o        (err_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_ack_i    (bus_ack_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard ----------------
    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_at;     // WAIT cycle (1-based) carrying ack, 0 = never
        logic [31:0] ack_rdata;
        logic        exp_mis;
        logic        exp_we;
        logic [31:0] exp_addr;
        int          exp_req;
        int          exp_stall;
        logic [31:0] exp_rdata;  // rdata_o in RESP (or held value after a misaligned access)
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int ack_at, input logic [31:0] ack_rdata,
                                input logic exp_mis, input logic exp_we,
                                input int exp_req, input int exp_stall,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.ack_at = ack_at; v.ack_rdata = ack_rdata; v.exp_mis = exp_mis;
        v.exp_we = exp_we; v.exp_addr = {addr[31:2], 2'b00}; v.exp_req = exp_req;
        v.exp_stall = exp_stall; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic drive_access(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata);
        mem_read_i  = rd;
        mem_write_i = wr;
        addr_i      = addr;
        wdata_i     = wdata;
    endtask

    task automatic run_vec(input vec_t v);
        int  stall_cnt;
        int  req_cnt;
        bit  stable;
        bit  mis_seen;
        bit  done;
        logic [31:0] exp;
        exp_q.push_back(v.exp_rdata);
        @(negedge clk_i);
        drive_access(v.rd, v.wr, v.addr, v.wdata);
        #1;
        if (v.exp_mis) begin
            check({v.name, ".mis"}, {31'd0, misaligned_o}, 32'd1);
            check({v.name, ".stall"}, {31'd0, stall_o}, 32'd0);
            check({v.name, ".rdata_zero"}, rdata_o, 32'd0);
            @(posedge clk_i); #1;
            check({v.name, ".req"}, {31'd0, bus_req_o}, 32'd0);
            @(negedge clk_i);
            drive_access(1'b0, 1'b0, 32'd0, 32'd0);
            #1;
            exp = exp_q.pop_front();
            check({v.name, ".rdata_held"}, rdata_o, exp);
            check({v.name, ".err"}, {31'd0, err_o}, {31'd0, v.exp_err});
        end else begin
            stall_cnt = 0; req_cnt = 0; stable = 1; mis_seen = 0; done = 0;
            for (int c = 0; c < 40 && !done; c++) begin
                if (c > 0) begin
                    @(negedge clk_i); #1;
                end
                if (misaligned_o) mis_seen = 1;
                if (bus_req_o) begin
                    req_cnt++;
                    if (bus_we_o !== v.exp_we || bus_addr_o !== v.exp_addr) stable = 0;
                    if (v.exp_we && bus_wdata_o !== v.wdata) stable = 0;
                    bus_ack_i   = (req_cnt == v.ack_at);
                    bus_rdata_i = bus_ack_i ? v.ack_rdata : 32'hBAD0_BAD0;
                end else begin
                    bus_ack_i   = 1'b0;
                    bus_rdata_i = 32'hBAD0_BAD0;
                end
                if (stall_o) begin
                    stall_cnt++;
                end else if (stall_cnt > 0) begin
                    done = 1;
                    exp = exp_q.pop_front();
                    check({v.name, ".rdata"}, rdata_o, exp);
                    check({v.name, ".err"}, {31'd0, err_o}, {31'd0, v.exp_err});
                    check({v.name, ".req_cycles"}, req_cnt, v.exp_req);
                    check({v.name, ".stall_cycles"}, stall_cnt, v.exp_stall);
                    check({v.name, ".bus_stable"}, {31'd0, stable}, 32'd1);
                    check({v.name, ".no_mis"}, {31'd0, mis_seen}, 32'd0);
                    drive_access(1'b0, 1'b0, 32'd0, 32'd0);
                end
            end
            if (!done) begin
                check({v.name, ".completed"}, 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
        end
    endtask

    // ---------------- test ----------------
    initial begin
        vecs.push_back(mk("load0",     1, 0, 32'h0000_0010, 32'h0,          1, 32'hDEAD_BEEF, 0, 0, 1, 2, 32'hDEAD_BEEF, 0));
        vecs.push_back(mk("store3",    0, 1, 32'h0000_0020, 32'h1234_5678,  4, 32'hFFFF_FFFF, 0, 1, 4, 5, 32'hDEAD_BEEF, 0));
        vecs.push_back(mk("mis_rd",    1, 0, 32'h0000_0013, 32'h0,          0, 32'h0,         1, 0, 0, 0, 32'hDEAD_BEEF, 0));
        vecs.push_back(mk("load2",     1, 0, 32'h0000_0044, 32'h0,          2, 32'hCAFE_F00D, 0, 0, 2, 3, 32'hCAFE_F00D, 0));
        vecs.push_back(mk("rdwr",      1, 1, 32'h0000_0040, 32'hA5A5_A5A5,  1, 32'h5555_5555, 0, 1, 1, 2, 32'hCAFE_F00D, 0));
        vecs.push_back(mk("mis_wr",    0, 1, 32'h0000_0042, 32'h0F0F_0F0F,  0, 32'h0,         1, 1, 0, 0, 32'hCAFE_F00D, 0));
        vecs.push_back(mk("timeout",   1, 0, 32'h0000_0080, 32'h0,          0, 32'h0,         0, 0, 4, 5, 32'h0000_0000, 1));
        vecs.push_back(mk("load_post", 1, 0, 32'h0000_0084, 32'h0,          1, 32'h1357_2468, 0, 0, 1, 2, 32'h1357_2468, 1));
        vecs.push_back(mk("mis_err",   1, 0, 32'h0000_0001, 32'h0,          0, 32'h0,         1, 0, 0, 0, 32'h1357_2468, 1));

        // reset state
        #12;
        check("rst.rdata", rdata_o, 32'd0);
        check("rst.stall", {31'd0, stall_o}, 32'd0);
        check("rst.mis", {31'd0, misaligned_o}, 32'd0);
        check("rst.err", {31'd0, err_o}, 32'd0);
        check("rst.req", {31'd0, bus_req_o}, 32'd0);
        check("rst.we", {31'd0, bus_we_o}, 32'd0);
        check("rst.addr", bus_addr_o, 32'd0);
        check("rst.wdata", bus_wdata_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // back-to-back loads with mem_read_i held through RESP
        @(negedge clk_i);
        drive_access(1'b1, 1'b0, 32'h0000_0200, 32'h0);
        #1;
        check("b2b.idle1_stall", {31'd0, stall_o}, 32'd1);
        check("b2b.idle1_req", {31'd0, bus_req_o}, 32'd0);
        @(negedge clk_i); #1;
        check("b2b.wait1_req", {31'd0, bus_req_o}, 32'd1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_1111;
        @(negedge clk_i); #1;
        bus_ack_i = 1'b0; bus_rdata_i = 32'hBAD0_BAD0;
        check("b2b.resp1_stall", {31'd0, stall_o}, 32'd0);
        check("b2b.resp1_req", {31'd0, bus_req_o}, 32'd0);
        check("b2b.resp1_rdata", rdata_o, 32'h1111_1111);
        addr_i = 32'h0000_0204;
        @(negedge clk_i); #1;
        check("b2b.idle2_stall", {31'd0, stall_o}, 32'd1);
        check("b2b.idle2_req", {31'd0, bus_req_o}, 32'd0);
        @(negedge clk_i); #1;
        check("b2b.wait2_req", {31'd0, bus_req_o}, 32'd1);
        check("b2b.wait2_addr", bus_addr_o, 32'h0000_0204);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h2222_2222;
        @(negedge clk_i); #1;
        bus_ack_i = 1'b0; bus_rdata_i = 32'hBAD0_BAD0;
        check("b2b.resp2_rdata", rdata_o, 32'h2222_2222);
        drive_access(1'b0, 1'b0, 32'd0, 32'd0);

        // ack outside WAIT is ignored
        @(negedge clk_i);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h9999_9999;
        @(posedge clk_i); #1;
        bus_ack_i = 1'b0; bus_rdata_i = 32'hBAD0_BAD0;
        check("stray_ack.rdata", rdata_o, 32'h2222_2222);
        check("stray_ack.req", {31'd0, bus_req_o}, 32'd0);

        // asynchronous reset in the middle of WAIT (err_o is 1 here)
        @(negedge clk_i);
        drive_access(1'b1, 1'b0, 32'h0000_0300, 32'h0);
        @(negedge clk_i); #1;
        check("arst.pre_req", {31'd0, bus_req_o}, 32'd1);
        #2 rst_i = 1'b0;
        #1;
        check("arst.req", {31'd0, bus_req_o}, 32'd0);
        check("arst.stall", {31'd0, stall_o}, 32'd0);
        check("arst.err", {31'd0, err_o}, 32'd0);
        check("arst.rdata", rdata_o, 32'd0);
        @(negedge clk_i);
        drive_access(1'b0, 1'b0, 32'd0, 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i); #1;
        check("arst.idle_stall", {31'd0, stall_o}, 32'd0);
        check("arst.idle_req", {31'd0, bus_req_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // global time limit
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1);
    end

endmodule
